// File: rtl/rv_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_ctrl
// Purpose  : Fetch-side controller for the instruction fetch buffer. Owns the
//            fetch PC and issues word-aligned bus reads while the buffer has
//            room. Live responses go to the buffer with the halfword-offset
//            flag, and the PC advances by the buffer-reported increment.
//            After a redirect, responses to earlier requests are counted as
//            stale and dropped.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_reset          clock; synchronous active-high reset
//   i_pc_select/i_pc_target redirect strobe and target
//   i_free_dword_or_more    buffer has room for two or more halfwords
//   i_pc_incr               fetch-PC advance for the current push (2 or 4)
//   o_bus_req/o_bus_addr    read address phase (address word aligned)
//   i_bus_gnt               address phase accepted
//   i_bus_ack/i_bus_rdata   in-order read data return
//   o_ack/o_data            live response to the buffer
//   o_fetch_pc1             only the high halfword of the word is wanted
//   o_pc_select             buffer flush (redirect or reset)
//   o_fetch_pc_next         buffer PC load value
//   o_busy                  bus reads outstanding
// ============================================================================
module rv_fetch_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pc_select,
    input  logic [31:0] i_pc_target,
    input  logic        i_free_dword_or_more,
    input  logic [31:0] i_pc_incr,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    input  logic        i_bus_gnt,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_ack,
    output logic [31:0] o_data,
    output logic        o_fetch_pc1,
    output logic        o_pc_select,
    output logic [31:0] o_fetch_pc_next,
    output logic        o_busy
);

    localparam int            CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        r_state_q,     w_state_d;
    logic [31:0]   r_fetch_pc_q,  w_fetch_pc_d;
    logic [31:0]   r_addr_q,      w_addr_d;
    logic [CW-1:0] r_outst_q,     w_outst_d;
    logic [CW-1:0] r_stale_q,     w_stale_d;
    // Pending request was overtaken by a redirect; it still has to be
    // granted (address phase is never withdrawn) but its data is discarded.
    logic          r_req_stale_q, w_req_stale_d;

    logic w_gnt;
    logic w_ack_any;
    logic w_ack_stale;
    logic w_ack_live;

    always_comb begin
        w_gnt       = (r_state_q == ST_REQ) && i_bus_gnt;
        // Guard against a spurious ack so the counters can never wrap.
        w_ack_any   = i_bus_ack && (r_outst_q != '0);
        // Acks return in order, so while stale requests remain the ack is
        // one of theirs.
        w_ack_stale = w_ack_any && (r_stale_q != '0);
        w_ack_live  = w_ack_any && (r_stale_q == '0) &&
                      (r_state_q == ST_WAIT) && !i_pc_select;
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_fetch_pc_d  = r_fetch_pc_q;
        w_addr_d      = r_addr_q;
        w_outst_d     = r_outst_q;
        w_stale_d     = r_stale_q;
        w_req_stale_d = r_req_stale_q;

        case ({w_gnt, w_ack_any})
            2'b10:   w_outst_d = r_outst_q + C_ONE;
            2'b01:   w_outst_d = r_outst_q - C_ONE;
            default: w_outst_d = r_outst_q;
        endcase

        if (i_pc_select) begin
            // Everything in flight after this cycle belongs to the old path.
            w_stale_d = w_outst_d;
        end else begin
            if (w_gnt && r_req_stale_q) begin
                w_stale_d = w_stale_d + C_ONE;
            end
            if (w_ack_stale) begin
                w_stale_d = w_stale_d - C_ONE;
            end
        end

        if (i_pc_select) begin
            w_fetch_pc_d = i_pc_target;
        end else if (w_ack_live) begin
            w_fetch_pc_d = r_fetch_pc_q + i_pc_incr;
        end

        case (r_state_q)
            ST_IDLE: begin
                if (i_free_dword_or_more && (r_outst_q < C_MAX) && !i_pc_select) begin
                    w_state_d     = ST_REQ;
                    w_addr_d      = {r_fetch_pc_q[31:2], 2'b00};
                    w_req_stale_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (i_pc_select) begin
                    w_req_stale_d = 1'b1;
                end
                if (i_bus_gnt) begin
                    w_state_d     = (r_req_stale_q || i_pc_select) ? ST_IDLE : ST_WAIT;
                    w_req_stale_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i_pc_select || w_ack_live) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q     <= ST_IDLE;
            r_fetch_pc_q  <= RESET_PC;
            r_addr_q      <= {RESET_PC[31:2], 2'b00};
            r_outst_q     <= '0;
            r_stale_q     <= '0;
            r_req_stale_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_fetch_pc_q  <= w_fetch_pc_d;
            r_addr_q      <= w_addr_d;
            r_outst_q     <= w_outst_d;
            r_stale_q     <= w_stale_d;
            r_req_stale_q <= w_req_stale_d;
        end
    end

    // Request, ack and busy are masked during reset so the bus and buffer
    // see a quiet interface in the reset cycle itself.
    assign o_bus_req       = (r_state_q == ST_REQ) && !i_reset;
    assign o_bus_addr      = r_addr_q;
    assign o_ack           = w_ack_live && !i_reset;
    assign o_data          = i_bus_rdata;
    assign o_fetch_pc1     = r_fetch_pc_q[1];
    assign o_pc_select     = i_pc_select || i_reset;
    assign o_fetch_pc_next = i_reset ? RESET_PC : i_pc_target;
    assign o_busy          = (r_outst_q != '0) && !i_reset;

endmodule
`default_nettype wire

// File: doc/rv_fetch_ctrl.md
Name: rv_fetch_ctrl

Overview:
Fetch-side controller that sequences instruction-bus reads for the fetch buffer (rv_fetch_buf). It owns the fetch PC and issues word-aligned read requests only while the buffer reports room. It forwards valid responses to the buffer with the halfword-offset flag, and advances the fetch PC by the buffer-reported increment. On a redirect it re-targets fetch and discards responses to requests issued before the redirect, so stale words never reach the buffer.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
MAX_OUTSTANDING, 2, max granted-but-unacked bus reads (stale plus live); >=1.

Ports:
i_clk  in  1  clock, all state updates on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_pc_select  in  1  redirect strobe from execute/branch unit.
i_pc_target  in  32  redirect target, valid with i_pc_select.
i_free_dword_or_more  in  1  buffer has room for >=2 halfwords.
i_pc_incr  in  32  buffer-reported fetch-PC advance (2 or 4) for the current push.
o_bus_req  out  1  read request, address phase.
o_bus_addr  out  32  word address, {fetch_pc[31:2],2'b00}.
i_bus_gnt  in  1  address phase accepted this cycle.
i_bus_ack  in  1  read data valid, in request order, >=1 cycle after gnt.
i_bus_rdata  in  32  read data.
o_ack  out  1  live (non-stale) response to the buffer.
o_data  out  32  i_bus_rdata pass-through.
o_fetch_pc1  out  1  fetch_pc[1]; high halfword only is wanted.
o_pc_select  out  1  flush to buffer; i_pc_select OR i_reset.
o_fetch_pc_next  out  32  buffer PC load value: RESET_PC in reset, else i_pc_target.
o_busy  out  1  outstanding count nonzero.

Behaviour:
- Reset (i_reset=1): fetch_pc=RESET_PC, state=IDLE, outstanding=0, stale=0.
  - o_bus_req=0, o_ack=0, o_busy=0, o_pc_select=1, o_fetch_pc_next=RESET_PC.
  - Reset mid-transaction abandons all counts. The bus must be quiesced by the same reset.
- States:
  - IDLE: no request.
  - REQ: o_bus_req=1, address held stable.
  - WAIT: live request granted, awaiting its ack.
- IDLE->REQ when all of the following hold:
  - i_free_dword_or_more=1,
  - no live request pending,
  - outstanding<MAX_OUTSTANDING,
  - no i_pc_select this cycle.
  - o_bus_req is registered: it rises the cycle after the condition holds.
- REQ->WAIT on i_bus_gnt; outstanding+1.
  - o_bus_addr and o_bus_req stay stable until gnt, even if a redirect arrives.
  - A redirect while in REQ marks that request stale once granted, then goes to IDLE.
- WAIT->IDLE on live ack:
  - o_ack=1 the same cycle (combinational from i_bus_ack and stale==0).
  - fetch_pc += i_pc_incr, sampled that cycle.
  - outstanding-1.
- Ack ordering: acks return in order, so an ack with stale>0 belongs to a stale request.
  - Stale ack: o_ack=0, stale-1, outstanding-1, fetch_pc unchanged.
- Redirect (i_pc_select=1) in any state:
  - fetch_pc<=i_pc_target.
  - stale<=outstanding (+1 if a pending REQ is granted this cycle).
  - Any ack in the same cycle is discarded: o_ack=0 and the count decrements apply.
  - Next state IDLE, or REQ kept until gnt as above.
- Simultaneous gnt+ack in one cycle: outstanding unchanged (+1-1).
- Width rules:
  - outstanding and stale are $clog2(MAX_OUTSTANDING+1) bits; they never wrap.
  - No issue is allowed while outstanding==MAX_OUTSTANDING.
  - fetch_pc add is 32-bit modulo; wrap 0xFFFF_FFFC+4=0.
- At most one live request is in flight. This guarantees buffer room for every live ack.
- o_busy = (outstanding!=0).

Test Plan:
- Reset release, RESET_PC=0x100, free=1, gnt next cycle, ack 2 cycles later:
  - o_bus_addr=0x100, o_ack pulses once with data.
  - With i_pc_incr=4, next request is to 0x104.
- Redirect to 0x202 while idle:
  - o_pc_select=1, o_fetch_pc_next=0x202.
  - Next o_bus_addr=0x200 with o_fetch_pc1=1; on ack with i_pc_incr=2, next addr=0x204.
- Redirect to 0x400 in WAIT for 0x108:
  - Ack for 0x108 gives o_ack=0.
  - Request to 0x400 is issued before that ack (outstanding=2), and its ack gives o_ack=1.
- Redirect while o_bus_req=1 with gnt held low 3 cycles:
  - o_bus_addr stays at the old address until gnt; that response is dropped.
  - Then a request to the target follows.
- i_free_dword_or_more=0 for 5 cycles after an ack:
  - No o_bus_req; the request appears the cycle after free returns to 1.
- Reset asserted in WAIT: next cycle outstanding=0, o_bus_req=0, o_busy=0, and o_fetch_pc_next=RESET_PC.
